// File: rtl/yutorina_if_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, fetch FSM state encodings and
// the NOP instruction word used to bubble the IF/ID register.
package yutorina_if_stage_pkg;

  // Word-address and instruction-data widths of the instruction bus.
  localparam int unsigned WORD_ADDR_W = 30;
  localparam int unsigned WORD_DATA_W = 32;

  // Instruction word that decode treats as a no-op.
  localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0000;

  // Fetch FSM states.
  //   FETCH : request at pc is on the bus
  //   HOLD  : fetched word parked in buf_insn while the pipe is stalled
  //   DRAIN : finishing a read that a redirect made stale
  typedef enum logic [1:0] {
    IF_STATE_FETCH = 2'd0,
    IF_STATE_HOLD  = 2'd1,
    IF_STATE_DRAIN = 2'd2
  } if_state_e;

endpackage

// File: rtl/yutorina_if_stage_if.sv
// Instruction-bus read channel between the fetch stage (master) and the
// instruction memory / bus slave.
//   req_c   : read request, combinational in the master
//   addr_c  : word address, combinational in the master, stable while req_c
//             is high and rdy is low
//   rdy     : read data valid this cycle, completes the request
//   rd_data : instruction word
interface yutorina_if_stage_if
  import yutorina_if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = WORD_ADDR_W,
  parameter int unsigned DATA_W = WORD_DATA_W
);

  logic              req_c;
  logic [ADDR_W-1:0] addr_c;
  logic              rdy;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_c,
    output addr_c,
    input  rdy,
    input  rd_data
  );

  modport slave (
    input  req_c,
    input  addr_c,
    output rdy,
    output rd_data
  );

endinterface

// File: rtl/yutorina_if_reg.sv
// IF/ID pipeline register. Flush has priority and inserts a bubble (NOP,
// valid deasserted); load captures a new {pc, insn}; otherwise it holds.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture pc_i/insn_i as a valid instruction
//   flush_i   : insert a bubble
//   pc_i      : word address of the incoming instruction
//   insn_i    : incoming instruction word
//   pc_o      : PC held in IF/ID
//   insn_o    : instruction held in IF/ID
//   en_n_o    : IF/ID valid, active-low
module yutorina_if_reg
  import yutorina_if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = WORD_ADDR_W,
  parameter int unsigned DATA_W = WORD_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [DATA_W-1:0] insn_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] insn_o,
  output logic              en_n_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] insn_q;
  logic              en_n_q;

  // PC is left untouched on a bubble; only insn/valid matter to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      insn_q <= DATA_W'(ISA_NOP);
      en_n_q <= 1'b1;
    end else if (flush_i) begin
      insn_q <= DATA_W'(ISA_NOP);
      en_n_q <= 1'b1;
    end else if (load_i) begin
      pc_q   <= pc_i;
      insn_q <= insn_i;
      en_n_q <= 1'b0;
    end
  end

  assign pc_o   = pc_q;
  assign insn_o = insn_q;
  assign en_n_o = en_n_q;

endmodule

// File: rtl/yutorina_if_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads on the instruction
// bus and feeds the IF/ID register. Handles bus wait states, parks a
// completed fetch while the pipe is stalled, and drains a read that was
// already outstanding when a redirect arrived.
//   clk, rst     : clock, synchronous active-high reset
//   stall_i      : pipeline stall (i_busy | d_busy); IF/ID holds when high
//   flush_i      : redirect pulse, qualifies new_pc_i
//   new_pc_i     : redirect target word address
//   ibus         : instruction-bus read channel (master side)
//   i_busy_c_o   : fetch cannot deliver this cycle (combinational)
//   if_pc_o      : PC of the instruction in IF/ID
//   if_insn_o    : instruction in IF/ID
//   if_en_n_o    : IF/ID valid, active-low
module yutorina_if_stage
  import yutorina_if_stage_pkg::*;
#(
  parameter int unsigned ADDR_W   = WORD_ADDR_W,
  parameter int unsigned DATA_W   = WORD_DATA_W,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic [ADDR_W-1:0]   new_pc_i,
  yutorina_if_stage_if.master ibus,
  output logic                i_busy_c_o,
  output logic [ADDR_W-1:0]   if_pc_o,
  output logic [DATA_W-1:0]   if_insn_o,
  output logic                if_en_n_o
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] buf_insn_q, buf_insn_d;

  logic              ifid_load;
  logic              ifid_flush;
  logic [DATA_W-1:0] ifid_insn;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_STATE_FETCH;
      pc_q       <= ADDR_W'(RESET_PC);
      req_addr_q <= ADDR_W'(RESET_PC);
      buf_insn_q <= DATA_W'(ISA_NOP);
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      buf_insn_q <= buf_insn_d;
    end
  end

  // Next-state logic; flush wins over every other event.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IF_STATE_FETCH: begin
        if (flush_i) begin
          // An un-returned read must complete before the bus can move on.
          state_d = ibus.rdy ? IF_STATE_FETCH : IF_STATE_DRAIN;
        end else if (ibus.rdy && stall_i) begin
          state_d = IF_STATE_HOLD;
        end
      end
      IF_STATE_HOLD: begin
        if (flush_i || !stall_i) begin
          state_d = IF_STATE_FETCH;
        end
      end
      IF_STATE_DRAIN: begin
        if (ibus.rdy) begin
          state_d = IF_STATE_FETCH;
        end
      end
      default: state_d = IF_STATE_FETCH;
    endcase
  end

  // Bus outputs, busy flag and datapath controls.
  always_comb begin
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    buf_insn_d  = buf_insn_q;
    ifid_load   = 1'b0;
    ifid_flush  = 1'b0;
    ifid_insn   = ibus.rd_data;
    ibus.req_c  = 1'b0;
    ibus.addr_c = pc_q;
    i_busy_c_o  = 1'b0;

    unique case (state_q)
      IF_STATE_FETCH: begin
        ibus.req_c  = !rst;
        ibus.addr_c = pc_q;
        i_busy_c_o  = !rst && !ibus.rdy;
        // Remember what is on the bus in case a redirect forces a drain.
        req_addr_d  = pc_q;
        if (flush_i) begin
          ifid_flush = 1'b1;
          pc_d       = new_pc_i;
        end else if (ibus.rdy) begin
          if (!stall_i) begin
            ifid_load = 1'b1;
            pc_d      = pc_q + ADDR_W'(1);
          end else begin
            buf_insn_d = ibus.rd_data;
          end
        end
      end
      IF_STATE_HOLD: begin
        ifid_insn = buf_insn_q;
        if (flush_i) begin
          ifid_flush = 1'b1;
          pc_d       = new_pc_i;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
          pc_d      = pc_q + ADDR_W'(1);
        end
      end
      IF_STATE_DRAIN: begin
        // Keep presenting the stale address until the slave answers.
        ibus.req_c  = !rst;
        ibus.addr_c = req_addr_q;
        i_busy_c_o  = !rst;
        if (flush_i) begin
          ifid_flush = 1'b1;
          pc_d       = new_pc_i;
        end
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  yutorina_if_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_reg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (pc_q),
    .insn_i  (ifid_insn),
    .pc_o    (if_pc_o),
    .insn_o  (if_insn_o),
    .en_n_o  (if_en_n_o)
  );

endmodule

// File: doc/yutorina_if_stage.md
# yutorina_if_stage

Instruction-fetch stage of the Yutorina CPU: owns the program counter, issues word reads on the instruction bus, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the pipeline control block. It consumes that block's `stall`, `flush` and `new_pc`, and feeds back `i_busy`, which the control block ORs into `stall`. It handles bus wait states, buffering of a completed fetch while the pipe is stalled, and redirects that arrive while a bus read is outstanding.

## Interface
- `ADDR_W`, 30: word-address width (byte address = {addr, 2'b00}).
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: word address fetched first after reset.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: pipeline stall from control (`i_busy | d_busy`); IF/ID holds when high.
- `flush` in 1: redirect pulse from control; valid with `new_pc`.
- `new_pc` in ADDR_W: redirect target word address.
- `bus_req` out 1: instruction-bus read request.
- `bus_addr` out ADDR_W: read word address; stable while `bus_req` is high.
- `bus_rdy` in 1: read data valid this cycle; completes the request.
- `bus_rd_data` in DATA_W: instruction word.
- `i_busy` out 1: fetch cannot deliver this cycle.
- `if_pc` out ADDR_W: PC of the instruction in IF/ID.
- `if_insn` out DATA_W: instruction in IF/ID.
- `if_en_` out 1: IF/ID valid, active-low.

## Operation
- States: FETCH, HOLD, DRAIN. Internal registers: `pc`, `req_addr` (address of the outstanding read), `buf_insn`.
- `bus_req` = (FETCH or DRAIN) and not `rst`. `bus_addr` = `pc` in FETCH and `req_addr` in DRAIN. `req_addr` loads `pc` every FETCH cycle.
- `i_busy` = (FETCH and not `bus_rdy`) or DRAIN. It is combinational from `bus_rdy`.
- `flush` has priority over all other events in every state:
  - IF/ID loads `if_en_`=1 and `if_insn`=NOP.
  - `pc` loads `new_pc`.
- FETCH:
  - If `flush` and `bus_rdy`: discard the returned data and stay in FETCH.
  - If `flush` and not `bus_rdy`: go to DRAIN.
  - If `bus_rdy` and not `stall`: IF/ID loads {`pc`, `bus_rd_data`, `if_en_`=0}, `pc` loads `pc`+1, stay in FETCH.
  - If `bus_rdy` and `stall`: `buf_insn` loads `bus_rd_data`, go to HOLD.
  - If not `bus_rdy`: IF/ID holds.
- HOLD (`bus_req`=0, `i_busy`=0):
  - If `flush`: go to FETCH.
  - If not `stall`: IF/ID loads {`pc`, `buf_insn`, 0}, `pc` loads `pc`+1, go to FETCH.
  - Otherwise: hold.
- DRAIN (completes the read issued before the redirect):
  - `bus_rdy`: discard data, go to FETCH.
  - `flush` in DRAIN: `pc` loads the newest `new_pc`.
  - Both in the same cycle: both actions apply.
- `pc`+1 wraps modulo 2^ADDR_W silently.

## Timing
- Reset, synchronous. State = FETCH, `pc` = RESET_PC, `req_addr` = RESET_PC, `buf_insn` = NOP, `if_pc` = 0, `if_insn` = NOP, `if_en_` = 1.
- While `rst` is high: `bus_req` = 0, `i_busy` = 0.
- Reset mid-request: the bus slave must treat the drop of `bus_req` as an abort.
- Zero-wait bus (`bus_rdy` in the same cycle as `bus_req`): one instruction per cycle, IF/ID updated at the next edge.
- Latency from `flush` to the first request at `new_pc`:
  - Next cycle, if there is no outstanding read or it completes that cycle.
  - Otherwise the cycle after DRAIN sees `bus_rdy`.
- `bus_addr` never changes while a request is pending without `bus_rdy`.

## Structure
- Shared `cpu.h` holds:
  - State encodings `IF_STATE_FETCH`/`HOLD`/`DRAIN`.
  - `ISA_NOP`.
  - `WordAddrBus` / `WordDataBus` widths.
- Sub-module `yutorina_if_reg`: the IF/ID pipeline register, with inputs for load, flush and data.
- The FSM and PC logic stay in the top module.

## Test plan
- Reset release, zero-wait bus returning `0x11111111`, `0x22222222`:
  - `bus_addr` is 0 then 1.
  - IF/ID shows {0, `0x11111111`} then {1, `0x22222222`}.
  - `if_en_` is 0 from the second cycle.
- `bus_rdy` delayed 3 cycles:
  - `i_busy` is high for 3 cycles.
  - `bus_addr` stays constant.
  - IF/ID holds.
- Fetch completes at `pc`=5 while `stall` is held 4 cycles by `d_busy`:
  - State is HOLD, `bus_req` is 0.
  - On release, IF/ID = {5, buffered word} and the next request is at 6.
- `flush` with `new_pc`=`0x100` while the read at 7 is pending 2 more cycles:
  - DRAIN keeps `bus_addr`=7.
  - The returned data is dropped and `if_en_` is 1.
  - The next request is at `0x100`.
- `flush` in DRAIN with `new_pc`=`0x200` after an earlier `0x100`: the next request is at `0x200`.
- `pc` = `0x3FFFFFFF`, zero-wait: the next `bus_addr` is 0.
